// File: rtl/fm_pkg.sv
// Shared types and sizing helpers for the multi-channel
// first-match checker.
package fm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_D = 2'd2
    } fm_state_t;

    // Bits needed to hold the value v (at least 1).
    function automatic int bits_for(input int v);
        int n;
        n = 1;
        while (n < 31 && (1 << n) <= v) begin
            n++;
        end
        return n;
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/fm_chan.sv
// One checker channel: rose(a) ##[1:B_MAX] b |=> ##[0:D_MAX] d |-> e.
// Ports: clk, rst, en, a, b, d, e in; pass, fail, tmo, busy out.
module fm_chan
    import fm_pkg::*;
#(
    parameter int B_MAX = 8,
    parameter int D_MAX = 16,
    parameter int WW    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic d,
    input  logic e,
    output logic pass,
    output logic fail,
    output logic tmo,
    output logic busy
);

    localparam logic [WW-1:0] B_LIM = WW'(B_MAX);
    localparam logic [WW-1:0] D_LIM = WW'(D_MAX);
    localparam logic [WW-1:0] ONE   = WW'(1);

    fm_state_t     state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          a_q;
    logic          rose;
    logic          pass_n, fail_n, tmo_n;

    assign rose = a & ~a_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
            a_q   <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            a_q   <= a;
            pass  <= pass_n;
            fail  <= fail_n;
            tmo   <= tmo_n;
        end
    end

    // wcnt holds the 1-based index of the current wait cycle;
    // in unbounded mode it is held at zero.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        pass_n  = 1'b0;
        fail_n  = 1'b0;
        tmo_n   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            wcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rose) begin
                        state_n = WAIT_B;
                        wcnt_n  = (B_MAX != 0) ? ONE : '0;
                    end
                end
                WAIT_B: begin
                    if (b) begin
                        state_n = WAIT_D;
                        wcnt_n  = (D_MAX != 0) ? ONE : '0;
                    end else if (B_MAX != 0 && wcnt == B_LIM) begin
                        state_n = IDLE;
                        wcnt_n  = '0;
                    end else if (B_MAX != 0) begin
                        wcnt_n = wcnt + ONE;
                    end
                end
                WAIT_D: begin
                    if (d) begin
                        state_n = IDLE;
                        wcnt_n  = '0;
                        pass_n  = e;
                        fail_n  = ~e;
                    end else if (D_MAX != 0 && wcnt == D_LIM) begin
                        state_n = IDLE;
                        wcnt_n  = '0;
                        tmo_n   = 1'b1;
                    end else if (D_MAX != 0) begin
                        wcnt_n = wcnt + ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fm_checker_multi.sv
// NCH independent checker channels plus a saturating fail counter.
// Ports: clk, rst, en, clr_cnt, a/b/d/e[NCH] in;
//        pass/fail/tmo/busy[NCH], fail_cnt, any_fail out.
module fm_checker_multi
    import fm_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int B_MAX = 8,
    parameter int D_MAX = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic [NCH-1:0]   a,
    input  logic [NCH-1:0]   b,
    input  logic [NCH-1:0]   d,
    input  logic [NCH-1:0]   e,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic [NCH-1:0]   tmo,
    output logic [NCH-1:0]   busy,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             any_fail
);

    localparam int WW    = bits_for(max2(B_MAX, D_MAX));
    localparam int PC_W  = bits_for(NCH);
    // One extra bit over the wider operand keeps the add from wrapping.
    localparam int SUM_W = max2(CNT_W, PC_W) + 1;
    localparam logic [SUM_W-1:0] SAT =
        {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fm_chan #(
            .B_MAX (B_MAX),
            .D_MAX (D_MAX),
            .WW    (WW)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a    (a[i]),
            .b    (b[i]),
            .d    (d[i]),
            .e    (e[i]),
            .pass (pass[i]),
            .fail (fail[i]),
            .tmo  (tmo[i]),
            .busy (busy[i])
        );
    end

    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;

    always_comb begin
        pc = '0;
        for (int i = 0; i < NCH; i++) begin
            pc = pc + PC_W'(fail[i]);
        end
        sum = SUM_W'(fail_cnt) + SUM_W'(pc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt <= '0;
            any_fail <= 1'b0;
        end else if (clr_cnt) begin
            fail_cnt <= '0;
            any_fail <= 1'b0;
        end else begin
            fail_cnt <= (sum > SAT) ? {CNT_W{1'b1}}
                                    : sum[CNT_W-1:0];
            if (|fail) begin
                any_fail <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fm_checker_multi.sv
// Bench for fm_checker_multi: directed table, corner sequences and
// random stimulus against a timestamp-based reference model.
module tb_fm_checker_multi;

    localparam int NCH   = 4;
    localparam int B_MAX = 8;
    localparam int D_MAX = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst, en, clr_cnt;
    logic [NCH-1:0]   a, b, d, e;
    logic [NCH-1:0]   pass, fail, tmo, busy;
    logic [CNT_W-1:0] fail_cnt;
    logic             any_fail;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    fm_checker_multi #(
        .NCH   (NCH),
        .B_MAX (B_MAX),
        .D_MAX (D_MAX),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr_cnt  (clr_cnt),
        .a        (a),
        .b        (b),
        .d        (d),
        .e        (e),
        .pass     (pass),
        .fail     (fail),
        .tmo      (tmo),
        .busy     (busy),
        .fail_cnt (fail_cnt),
        .any_fail (any_fail)
    );

    always #5 clk = ~clk;

    // Reference model: phase per channel plus cycle timestamps.
    int         ph [NCH];
    int         t0 [NCH];
    int         tb [NCH];
    int         now = 0;
    logic [3:0] m_aq, m_pass, m_fail, m_tmo;
    int         m_cnt;
    logic       m_any;

    task automatic model_step(input logic r, input logic en_v,
                              input logic c, input logic [3:0] av,
                              input logic [3:0] bv, input logic [3:0] dv,
                              input logic [3:0] ev);
        logic [3:0] np, nf, nt;
        np = '0; nf = '0; nt = '0;
        if (r) begin
            for (int i = 0; i < NCH; i++) ph[i] = 0;
            m_aq = '0; m_cnt = 0; m_any = 1'b0;
        end else begin
            if (c) begin
                m_cnt = 0; m_any = 1'b0;
            end else begin
                m_cnt = m_cnt + $countones(m_fail);
                if (m_cnt > CMAX) m_cnt = CMAX;
                if (m_fail != 0) m_any = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!en_v) begin
                    ph[i] = 0;
                end else if (ph[i] == 0) begin
                    if (av[i] && !m_aq[i]) begin
                        ph[i] = 1; t0[i] = now;
                    end
                end else if (ph[i] == 1) begin
                    if (bv[i]) begin
                        ph[i] = 2; tb[i] = now;
                    end else if (now - t0[i] >= B_MAX) begin
                        ph[i] = 0;
                    end
                end else begin
                    if (dv[i]) begin
                        ph[i] = 0; np[i] = ev[i]; nf[i] = !ev[i];
                    end else if (now - tb[i] >= D_MAX) begin
                        ph[i] = 0; nt[i] = 1'b1;
                    end
                end
            end
            m_aq = av;
        end
        m_pass = np; m_fail = nf; m_tmo = nt;
        now++;
    endtask

    function automatic logic [3:0] m_busy();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (ph[i] != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: drive, step model, compare the whole output bundle.
    task automatic cyc(input logic r, input logic en_v, input logic c,
                       input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] dv, input logic [3:0] ev);
        logic [21:0] got, exp;
        rst = r; en = en_v; clr_cnt = c;
        a = av; b = bv; d = dv; e = ev;
        @(posedge clk);
        model_step(r, en_v, c, av, bv, dv, ev);
        #1;
        got = {pass, fail, tmo, busy, fail_cnt, any_fail};
        exp = {m_pass, m_fail, m_tmo, m_busy(), 4'(m_cnt), m_any};
        pulses += $countones(pass | fail | tmo);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model t=%0d got=%h exp=%h", now, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a, b, d, e;
        logic [3:0] p, f, t, bz;
        int         cnt;
        logic       any;
    } vec_t;

    vec_t tbl [11];

    task automatic round(input logic [3:0] m, input logic [3:0] ev);
        cyc(0, 1, 0, m, 0, 0, 0);
        cyc(0, 1, 0, m, m, 0, 0);
        cyc(0, 1, 0, 0, 0, m, ev);
        cyc(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0};
        tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0};
        tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0};
        tbl[3]  = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0};
        tbl[4]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0};
        tbl[5]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0};
        tbl[6]  = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0};
        tbl[7]  = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0};
        tbl[8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0};
        tbl[9]  = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 0, 0};
        tbl[10] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1};

        m_pass = '0; m_fail = '0; m_tmo = '0; m_aq = '0;
        m_cnt = 0; m_any = 1'b0;
        for (int i = 0; i < NCH; i++) ph[i] = 0;

        // Reset state
        cyc(1, 1, 1, 4'hF, 4'hF, 4'hF, 4'hF);
        cyc(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("reset_out", {pass, fail, tmo, busy}, 0);
        chk("reset_cnt", {fail_cnt, any_fail}, 0);

        // Directed table: pass on ch0, fail with first-match on ch1
        for (int i = 0; i < 11; i++) begin
            cyc(0, 1, 0, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
            chk($sformatf("tbl%0d_vec", i),
                {pass, fail, tmo, busy},
                {tbl[i].p, tbl[i].f, tbl[i].t, tbl[i].bz});
            chk($sformatf("tbl%0d_cnt", i),
                {fail_cnt, any_fail}, {4'(tbl[i].cnt), tbl[i].any});
        end

        // b never arrives: vacuous return after B_MAX cycles
        pulses = 0;
        cyc(0, 1, 0, 4'h4, 0, 0, 0);
        repeat (7) cyc(0, 1, 0, 4'h4, 0, 0, 0);
        chk("btmo_busy7", busy[2], 1);
        cyc(0, 1, 0, 4'h4, 0, 0, 0);
        chk("btmo_idle", busy[2], 0);
        chk("btmo_nopulse", pulses, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // d never arrives: one tmo after D_MAX cycles
        pulses = 0;
        cyc(0, 1, 0, 4'h8, 0, 0, 0);
        cyc(0, 1, 0, 0, 4'h8, 0, 0);
        repeat (15) cyc(0, 1, 0, 0, 0, 0, 0);
        chk("dtmo_early", tmo, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("dtmo_pulse", tmo, 4'h8);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("dtmo_once", pulses, 1);

        // b only in the rose(a) cycle: no verdict
        pulses = 0;
        cyc(0, 1, 0, 4'h1, 4'h1, 0, 0);
        repeat (10) cyc(0, 1, 0, 4'h1, 0, 4'h1, 4'h1);
        chk("sameb_none", pulses, 0);
        chk("sameb_idle", busy[0], 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Second rose(a) while busy is ignored
        pulses = 0;
        cyc(0, 1, 0, 4'h2, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 4'h2, 0, 0, 0);
        cyc(0, 1, 0, 4'h2, 4'h2, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'h2, 4'h2);
        repeat (20) cyc(0, 1, 0, 0, 4'h2, 4'h2, 0);
        chk("restart_one", pulses, 1);

        // Saturation with all channels failing together
        cyc(0, 1, 1, 0, 0, 0, 0);
        repeat (3) round(4'hF, 4'h0);
        round(4'h1, 4'h0);
        chk("sat_pre", fail_cnt, CMAX - 2);
        round(4'hF, 4'h0);
        chk("sat_max", fail_cnt, CMAX);
        chk("sat_any", any_fail, 1);

        // Clear wins over a same-cycle increment
        cyc(0, 1, 0, 4'h1, 0, 0, 0);
        cyc(0, 1, 0, 4'h1, 4'h1, 0, 0);
        cyc(0, 1, 0, 0, 0, 4'h1, 4'h0);
        chk("clr_failhi", fail, 4'h1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("clr_cnt", fail_cnt, 0);
        chk("clr_any", any_fail, 0);

        // Reset in WAIT_D aborts with no verdict
        pulses = 0;
        cyc(0, 1, 0, 4'hF, 0, 0, 0);
        cyc(0, 1, 0, 4'hF, 4'hF, 0, 0);
        cyc(1, 1, 1, 0, 0, 4'hF, 4'hF);
        chk("rst_busy", busy, 0);
        cyc(0, 1, 0, 0, 0, 4'hF, 4'hF);
        chk("rst_nopulse", pulses, 0);

        // Enable low drops an attempt
        cyc(0, 1, 0, 4'h1, 0, 0, 0);
        cyc(0, 0, 0, 4'h1, 4'h1, 0, 0);
        chk("en_idle", busy, 0);
        cyc(0, 1, 0, 4'h1, 4'h1, 4'h1, 4'h1);
        chk("en_no_rose", busy, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 400) == 0, ($urandom % 40) != 0,
                ($urandom % 80) == 0, 4'($urandom),
                4'($urandom & $urandom & $urandom),
                4'($urandom & $urandom & $urandom),
                4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fm_checker_multi.md
FM_CHECKER_MULTI -- requirements
Module: fm_checker_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent checker channels, 1..32.
REQ-002 Parameter B_MAX, default 8: max cycles after rose(a) to wait for b; 0 = unbounded.
REQ-003 Parameter D_MAX, default 16: max cycles in WAIT_D to wait for d; 0 = unbounded.
REQ-004 Parameter CNT_W, default 16: width of fail_cnt.
REQ-005 clk  input  1  sole clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  global enable; low forces all channels to IDLE.
REQ-008 clr_cnt  input  1  synchronous clear of fail_cnt and any_fail.
REQ-009 a, b, d, e  input  NCH each  per-channel trigger, antecedent-end, check-point, and expected signals.
REQ-010 pass, fail, tmo  output  NCH each  one-cycle verdict pulses per channel.
REQ-011 busy  output  NCH  channel is in WAIT_B or WAIT_D.
REQ-012 fail_cnt  output  CNT_W  saturating total of fail pulses.
REQ-013 any_fail  output  1  sticky, set by any fail pulse.

Function
REQ-014 Each channel SHALL check: first_match(rose(a) ##[1:B_MAX] b) |=> first_match(##[0:D_MAX] d) |-> e.
REQ-015 rose(a) SHALL be a & ~a_q, with a_q a per-channel register of a, reset to 0.
REQ-016 States: IDLE, WAIT_B, WAIT_D; IDLE -> WAIT_B on rose(a) while en=1.
REQ-017 b in the same cycle as rose(a) SHALL NOT end WAIT_B; only b in cycles 1..B_MAX after it counts.
REQ-018 WAIT_B -> WAIT_D at the edge after the first qualifying b; later b pulses are ignored.
REQ-019 If B_MAX>0 and no b within B_MAX cycles, the channel SHALL return to IDLE with no pulse (vacuous).
REQ-020 In WAIT_D, d in the first WAIT_D cycle (cycle after b) SHALL count.
REQ-021 On the first d in WAIT_D, the channel SHALL sample e in the same cycle and, in the next cycle, pulse pass if e=1 or fail if e=0, while entering IDLE.
REQ-022 If D_MAX>0 and no d within D_MAX WAIT_D cycles, the channel SHALL pulse tmo for one cycle and enter IDLE.
REQ-023 rose(a) while busy SHALL be ignored: no restart and no second thread.
REQ-024 rose(a) in the cycle a verdict pulse is high SHALL start a new attempt.
REQ-025 At most one of pass, fail, tmo per channel SHALL be high in any cycle.
REQ-026 fail_cnt SHALL add the popcount of that cycle's fail vector and saturate at 2^CNT_W-1.
REQ-027 Counter width SHALL be computed so that the popcount add cannot wrap.
REQ-028 clr_cnt SHALL take priority over a same-cycle increment; the result is 0.
REQ-029 en=0 SHALL force IDLE with no pulses.
REQ-030 a_q SHALL continue tracking a while en=0.
REQ-031 Wait counters SHALL be sized ceil(log2(max(B_MAX,D_MAX)+1)) bits.
REQ-032 With unbounded mode (0), wait counters SHALL be frozen and not wrap.

Reset
REQ-033 rst=1 SHALL set all states to IDLE, a_q=0, wait counters=0, pass/fail/tmo/busy=0, fail_cnt=0, any_fail=0 at the next edge.
REQ-034 rst mid-attempt SHALL abort without any verdict pulse.
REQ-035 rst SHALL take priority over en and clr_cnt.

Structure
REQ-036 Package fm_pkg SHALL hold the state enum (IDLE, WAIT_B, WAIT_D) and the counter-width function.
REQ-037 Sub-module fm_chan SHALL implement one channel FSM, including a_q and wait counter; the top SHALL instantiate NCH copies and the fail counter.

Verification
REQ-038 Pass: ch0, a 0->1 at c10, b at c12, d&e at c13 -> pass[0]=1 at c14, fail_cnt=0.
REQ-039 Fail and first-match: ch1, rose(a) c5, b c6, d e=0 c9, then d e=1 c10 -> fail[1] at c10 only, fail_cnt=1, any_fail=1.
REQ-040 Timeouts, with B_MAX=8 and D_MAX=16:
  - rose(a) with no b for 8 cycles -> back to IDLE, no pulse;
  - b at c3 with no d for 16 cycles -> tmo pulsed once.
REQ-041 Same-cycle b and restart: rose(a) with b in the same cycle and no later b -> no verdict. rose(a) at c2, second rose(a) at c4 while busy -> exactly one verdict.
REQ-042 Simultaneous fails: fails on all 4 channels in one cycle with fail_cnt=2^CNT_W-3 -> saturates at 2^CNT_W-1.
REQ-043 Clear versus increment: clr_cnt in the same cycle as a fail -> fail_cnt=0.
REQ-044 Reset mid-attempt: rst high in WAIT_D -> no pulses and all busy=0 on the next cycle.
